// File: rtl/vtg_pattern.sv
`default_nettype none
// ============================================================================
// Module   : vtg_pattern
// Purpose  : Video timing generator with bars / ramp / solid / checker output.
// Revision : 1.0 - initial release
// ============================================================================
module vtg_pattern #(
    parameter int PIXEL_WIDTH = 8,
    parameter int H_ACTIVE    = 1920,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_ACTIVE    = 1080,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter int CHECK_LOG2  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 pattern_sel,
    input  logic [PIXEL_WIDTH*3-1:0]   color_i,
    output logic [PIXEL_WIDTH*3-1:0]   do_o,
    output logic                       de_o,
    output logic                       hs_o,
    output logic                       vs_o,
    output logic                       sof_o,
    output logic                       busy_o
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);
    localparam int c_BAR_W   = H_ACTIVE / 8;
    localparam int c_BW      = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;

    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_START = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_H_ONE    = c_HW'(1);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_START = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_VW-1:0] c_V_ONE    = c_VW'(1);
    localparam logic [c_BW-1:0] c_BAR_LAST = c_BW'(c_BAR_W - 1);
    localparam logic [c_BW-1:0] c_BAR_ONE  = c_BW'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [c_HW-1:0]          hcnt_q, hcnt_d;
    logic [c_VW-1:0]          vcnt_q, vcnt_d;
    logic [c_BW-1:0]          bar_cnt_q, bar_cnt_d;
    logic [2:0]               bar_idx_q, bar_idx_d;
    logic [1:0]               sel_q;
    logic [PIXEL_WIDTH*3-1:0] color_q;
    logic [PIXEL_WIDTH*3-1:0] do_q;
    logic                     de_q, hs_q, vs_q, sof_q, busy_q;

    logic                     w_run, w_sof_pos, w_de, w_hs, w_vs;
    logic                     w_hchk, w_vchk;
    logic [1:0]               w_sel;
    logic [PIXEL_WIDTH*3-1:0] w_color, w_pix;
    logic [PIXEL_WIDTH-1:0]   w_ramp;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            c_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en) state_d = c_RUN;
            end
            default: begin
                if (hcnt_q == c_H_LAST) begin
                    hcnt_d = '0;
                    if (vcnt_q == c_V_LAST) begin
                        vcnt_d = '0;
                        // Stop request only takes effect at the frame boundary.
                        if (!en) state_d = c_IDLE;
                    end else begin
                        vcnt_d = vcnt_q + c_V_ONE;
                    end
                end else begin
                    hcnt_d = hcnt_q + c_H_ONE;
                end
            end
        endcase
    end

    // Bar index tracks hcnt / c_BAR_W incrementally, restarting with each line.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (hcnt_d == '0) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == c_BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_cnt_d = bar_cnt_q + c_BAR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    generate
        if (PIXEL_WIDTH <= c_HW) begin : g_ramp_slice
            assign w_ramp = hcnt_q[PIXEL_WIDTH-1:0];
        end else begin : g_ramp_pad
            assign w_ramp = {{(PIXEL_WIDTH - c_HW){1'b0}}, hcnt_q};
        end
        if (CHECK_LOG2 < c_HW) begin : g_hchk_bit
            assign w_hchk = hcnt_q[CHECK_LOG2];
        end else begin : g_hchk_zero
            assign w_hchk = 1'b0;
        end
        if (CHECK_LOG2 < c_VW) begin : g_vchk_bit
            assign w_vchk = vcnt_q[CHECK_LOG2];
        end else begin : g_vchk_zero
            assign w_vchk = 1'b0;
        end
    endgenerate

    assign w_run     = (state_q == c_RUN);
    assign w_sof_pos = w_run && (hcnt_q == '0) && (vcnt_q == '0);
    assign w_de      = (hcnt_q < c_H_ACT) && (vcnt_q < c_V_ACT);
    assign w_hs      = (hcnt_q >= c_HS_START) && (hcnt_q < c_HS_END);
    assign w_vs      = (vcnt_q >= c_VS_START) && (vcnt_q < c_VS_END);
    // First pixel of a frame uses the live selection, which is latched at the same time.
    assign w_sel     = w_sof_pos ? pattern_sel : sel_q;
    assign w_color   = w_sof_pos ? color_i : color_q;

    always_comb begin
        w_pix = '0;
        case (w_sel)
            2'd0:    w_pix = {{PIXEL_WIDTH{~bar_idx_q[0]}},
                              {PIXEL_WIDTH{~bar_idx_q[2]}},
                              {PIXEL_WIDTH{~bar_idx_q[1]}}};
            2'd1:    w_pix = {3{w_ramp}};
            2'd2:    w_pix = w_color;
            default: w_pix = {(3*PIXEL_WIDTH){~(w_hchk ^ w_vchk)}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            color_q <= '0;
            do_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (w_sof_pos) begin
                sel_q   <= pattern_sel;
                color_q <= color_i;
            end
            do_q   <= (w_run && w_de) ? w_pix : '0;
            de_q   <= w_run && w_de;
            hs_q   <= w_run && w_hs;
            vs_q   <= w_run && w_vs;
            sof_q  <= w_sof_pos;
            busy_q <= w_run;
        end
    end

    assign do_o   = do_q;
    assign de_o   = de_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign sof_o  = sof_q;
    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vtg_pattern.sv
`default_nettype none
// ============================================================================
// Module   : tb_vtg_pattern
// Purpose  : Scoreboard bench for vtg_pattern on a 24x8 raster (16x4 active).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vtg_pattern;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] color_i = 24'h0;
    logic [23:0] do_o, do2;
    logic        de_o, hs_o, vs_o, sof_o, busy_o;
    logic        de2, hs2, vs2, sof2, busy2;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] sb[$];
    logic [23:0] exp_px;

    always #5 clk = ~clk;

    vtg_pattern #(
        .PIXEL_WIDTH(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .CHECK_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .color_i(color_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .sof_o(sof_o), .busy_o(busy_o)
    );

    // Taller raster so that checker line 4 is visible.
    vtg_pattern #(
        .PIXEL_WIDTH(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2), .CHECK_LOG2(2)
    ) dut2 (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .color_i(color_i),
        .do_o(do2), .de_o(de2), .hs_o(hs2), .vs_o(vs2), .sof_o(sof2), .busy_o(busy2)
    );

    function automatic logic [23:0] pix_exp(input int sel, input logic [23:0] col,
                                            input int h, input int v);
        logic [7:0] r;
        r = 8'(h);
        case (sel)
            0: case (h / 2)
                   0: return 24'hFFFFFF;
                   1: return 24'h00FFFF;
                   2: return 24'hFFFF00;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'h0000FF;
                   6: return 24'hFF0000;
                   default: return 24'h000000;
               endcase
            1: return {r, r, r};
            2: return col;
            default: return ((((h >> 2) ^ (v >> 2)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
        endcase
    endfunction

    task automatic push_frame(input int sel, input logic [23:0] col);
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 16; h++)
                sb.push_back(pix_exp(sel, col, h, v));
    endtask

    // Resets the DUTs, then raises en; returns at the sample point of pixel (0,0).
    task automatic start_run(input logic [1:0] sel, input logic [23:0] col);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; pattern_sel = sel; color_i = col;
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (de_o === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pixel_unexpected: got %h while nothing was expected", do_o);
            end else begin
                exp_px = sb.pop_front();
                if (do_o !== exp_px) begin
                    n_err++;
                    $display("FAIL pixel: got %h expected %h", do_o, exp_px);
                end
            end
        end
    end

    task automatic test_reset;
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({do_o, de_o, hs_o, vs_o, sof_o, busy_o} !== 29'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", {do_o, de_o, hs_o, vs_o, sof_o, busy_o});
        end
        n_vec++;
        if (busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy2: got %b expected 0", busy2);
        end
        en = 1'b0;
    endtask

    task automatic test_timing;
        logic [4:0] got, want;
        int h, v;
        push_frame(0, 24'h0);
        push_frame(0, 24'h0);
        start_run(2'd0, 24'h0);
        for (int k = 0; k < 384; k++) begin
            h = k % 24;
            v = (k / 24) % 8;
            got  = {de_o, hs_o, vs_o, sof_o, busy_o};
            want = {(h < 16 && v < 4), (h >= 18 && h < 21), (v == 5), (h == 0 && v == 0), 1'b1};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL timing k=%0d: got de/hs/vs/sof/busy %b expected %b", k, got, want);
            end
            if (k == 200) en = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if ({do_o, de_o, hs_o, vs_o, sof_o, busy_o} !== 29'd0) begin
            n_err++;
            $display("FAIL timing_stop_idle: got %h expected 0", {do_o, de_o, hs_o, vs_o, sof_o, busy_o});
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL timing_drain: got %0d pixels left expected 0", sb.size());
        end
    endtask

    task automatic test_ramp_checker;
        push_frame(1, 24'h0);
        push_frame(3, 24'h0);
        start_run(2'd1, 24'h0);
        for (int k = 0; k < 390; k++) begin
            if (k == 60)  pattern_sel = 2'd3;
            if (k == 250) en = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (busy_o !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL ramp_checker_end: got busy %b left %0d expected busy 0 left 0", busy_o, sb.size());
        end
    endtask

    task automatic test_latch;
        push_frame(0, 24'h0);
        push_frame(2, 24'h123456);
        start_run(2'd0, 24'h123456);
        for (int k = 0; k < 390; k++) begin
            if (k == 70)  pattern_sel = 2'd2;
            if (k == 250) en = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (busy_o !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL latch_end: got busy %b left %0d expected busy 0 left 0", busy_o, sb.size());
        end
    endtask

    task automatic test_checker_tall;
        int h, v;
        push_frame(3, 24'h0);
        start_run(2'd3, 24'h0);
        for (int k = 0; k < 300; k++) begin
            h = k % 24;
            v = k / 24;
            if (k < 288 && (v == 0 || v == 4) && h < 16) begin
                n_vec++;
                if (de2 !== 1'b1 || do2 !== pix_exp(3, 24'h0, h, v)) begin
                    n_err++;
                    $display("FAIL checker_tall (%0d,%0d): got de %b px %h expected de 1 px %h",
                             h, v, de2, do2, pix_exp(3, 24'h0, h, v));
                end
            end
            if (k == 150) en = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if ({do2, de2, hs2, vs2, sof2, busy2, busy_o} !== 30'd0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL checker_tall_end: got %h left %0d expected 0 left 0",
                     {do2, de2, hs2, vs2, sof2, busy2, busy_o}, sb.size());
        end
    endtask

    task automatic test_stop;
        push_frame(1, 24'h0);
        push_frame(1, 24'h0);
        start_run(2'd1, 24'h0);
        for (int k = 0; k < 192; k++) begin
            if (k == 48) en = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if ({do_o, de_o, hs_o, vs_o, sof_o, busy_o} !== 29'd0) begin
            n_err++;
            $display("FAIL stop_idle: got %h expected 0", {do_o, de_o, hs_o, vs_o, sof_o, busy_o});
        end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n_vec++;
        if (sof_o !== 1'b0) begin
            n_err++;
            $display("FAIL restart_early: got sof %b expected 0", sof_o);
        end
        @(negedge clk);
        n_vec++;
        if (sof_o !== 1'b1) begin
            n_err++;
            $display("FAIL restart_sof: got sof %b expected 1", sof_o);
        end
        for (int j = 1; j <= 192; j++) @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL restart_end: got busy %b left %0d expected busy 0 left 0", busy_o, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        push_frame(0, 24'h0);
        start_run(2'd0, 24'h0);
        for (int k = 0; k < 29; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({do_o, de_o, hs_o, vs_o, sof_o, busy_o} !== 29'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h expected 0", {do_o, de_o, hs_o, vs_o, sof_o, busy_o});
        end
        rst = 1'b0;
        sb.delete();
        push_frame(0, 24'h0);
        @(negedge clk);
        n_vec++;
        if (sof_o !== 1'b0 || de_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_partial: got sof %b de %b expected 0 0", sof_o, de_o);
        end
        @(negedge clk);
        n_vec++;
        if (sof_o !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_sof: got sof %b expected 1", sof_o);
        end
        for (int j = 1; j <= 192; j++) begin
            if (j == 10) en = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (busy_o !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL midreset_end: got busy %b left %0d expected busy 0 left 0", busy_o, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_ramp_checker();
        test_latch();
        test_checker_tall();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
